// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode command sequencer.
// Holds the FSM state typedefs, the framing constants and the CRC-7 byte update.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SEND,
    ST_POLL,
    ST_EXTRA,
    ST_DONE
  } sd_state_e;

  // Per-byte handshake with the SPI byte engine
  typedef enum logic [1:0] {
    XP_LAUNCH,
    XP_RISE,
    XP_FALL,
    XP_SAMPLE
  } xfer_ph_e;

  localparam logic [6:0] CRC7_POLY   = 7'h09;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;
  localparam logic [1:0] START_PFX   = 2'b01;
  localparam int         FRAME_BYTES = 6;
  localparam int         EXTRA_BYTES = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // x^7+x^3+1, MSB first, one byte per call
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] din);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ din[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ CRC7_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Byte-wide CRC-7 accumulator for SD command frames.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = '0;
    else if (en) crc_d = crc7_byte(crc_q, din);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD SPI-mode command sequencer: filler bytes, 6-byte frame with CRC-7,
// R1 polling with timeout and optional 4-byte trailer, over a byte engine.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int RESP_POLL_MAX = 8,
  parameter int PRE_FF        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_extra,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic [7:0]  r1,
  output logic [31:0] resp_data,
  output logic        timeout,
  output logic [7:0]  spi_tx_data,
  output logic        spi_start,
  input  logic        spi_busy,
  input  logic [7:0]  spi_rx_data
);

  localparam int CNT_MAX = max_int(max_int(RESP_POLL_MAX, PRE_FF), FRAME_BYTES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sd_state_e        state_q, state_d;
  xfer_ph_e         xph_q, xph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       idx_q, idx_d;
  logic [31:0]      arg_q, arg_d;
  logic             extra_q, extra_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             start_q, start_d, tmo_q, tmo_d;
  logic [7:0]       tx_q, tx_d, r1_q, r1_d;
  logic [31:0]      resp_q, resp_d;
  logic [7:0]       byte_nxt;
  logic             byte_done, crc_clr, crc_en;
  logic [6:0]       crc;

  sd_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (byte_nxt),
    .crc   (crc)
  );

  always_comb begin
    byte_nxt = FILL_BYTE;
    if (state_q == ST_SEND) begin
      case (int'(cnt_q))
        0:       byte_nxt = {START_PFX, idx_q};
        1:       byte_nxt = arg_q[31:24];
        2:       byte_nxt = arg_q[23:16];
        3:       byte_nxt = arg_q[15:8];
        4:       byte_nxt = arg_q[7:0];
        5:       byte_nxt = {crc, 1'b1};
        default: byte_nxt = FILL_BYTE;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    xph_d     = xph_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    arg_d     = arg_q;
    extra_d   = extra_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    start_d   = 1'b0;
    tmo_d     = tmo_q;
    tx_d      = tx_q;
    r1_d      = r1_q;
    resp_d    = resp_q;
    byte_done = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;

    // tx_q only moves at launch, so the byte is stable for the whole engine cycle
    if (state_q != ST_IDLE && state_q != ST_DONE) begin
      case (xph_q)
        XP_LAUNCH: begin
          tx_d    = byte_nxt;
          start_d = 1'b1;
          xph_d   = XP_RISE;
          crc_en  = (state_q == ST_SEND) && (int'(cnt_q) < FRAME_BYTES - 1);
        end
        XP_RISE:   if (spi_busy)  xph_d = XP_FALL;
        XP_FALL:   if (!spi_busy) xph_d = XP_SAMPLE;
        XP_SAMPLE: begin
          xph_d     = XP_LAUNCH;
          byte_done = 1'b1;
        end
        default:   xph_d = XP_LAUNCH;
      endcase
    end

    case (state_q)
      ST_IDLE: if (cmd_start) begin
        idx_d   = cmd_index;
        arg_d   = cmd_arg;
        extra_d = resp_extra;
        busy_d  = 1'b1;
        tmo_d   = 1'b0;
        resp_d  = '0;
        crc_clr = 1'b1;
        cnt_d   = '0;
        xph_d   = XP_LAUNCH;
        state_d = (PRE_FF > 0) ? ST_PRE : ST_SEND;
      end
      ST_PRE: if (byte_done) begin
        if (int'(cnt_q) == PRE_FF - 1) begin
          state_d = ST_SEND;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_SEND: if (byte_done) begin
        if (int'(cnt_q) == FRAME_BYTES - 1) begin
          state_d = ST_POLL;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_POLL: if (byte_done) begin
        if (!spi_rx_data[7]) begin
          r1_d  = spi_rx_data;
          cnt_d = '0;
          if (extra_q) state_d = ST_EXTRA;
          else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else if (int'(cnt_q) == RESP_POLL_MAX - 1) begin
          r1_d    = FILL_BYTE;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_EXTRA: if (byte_done) begin
        resp_d = {resp_q[23:0], spi_rx_data};
        if (int'(cnt_q) == EXTRA_BYTES - 1) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      // One dead cycle: a start coincident with cmd_done is dropped here
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      xph_q   <= XP_LAUNCH;
      cnt_q   <= '0;
      idx_q   <= '0;
      arg_q   <= '0;
      extra_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
      tx_q    <= FILL_BYTE;
      r1_q    <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      xph_q   <= xph_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      extra_q <= extra_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
      tx_q    <= tx_d;
      r1_q    <= r1_d;
      resp_q  <= resp_d;
    end
  end

  assign cmd_busy    = busy_q;
  assign cmd_done    = done_q;
  assign r1          = r1_q;
  assign resp_data   = resp_q;
  assign timeout     = tmo_q;
  assign spi_tx_data = tx_q;
  assign spi_start   = start_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Table-driven bench for sd_cmd_sequencer with a behavioural SPI byte-engine model.
module tb_sd_cmd_sequencer;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        extra;
    int          pos;     // poll index carrying R1 (>=8 means never)
    logic [7:0]  noise;   // poll bytes before R1 (bit7 set)
    logic [7:0]  r1b;
    logic [31:0] xw;      // trailer bytes following R1
    logic [7:0]  crc_b;   // expected last frame byte
    logic [7:0]  e_r1;
    logic [31:0] e_resp;
    logic        e_tmo;
    int          e_bytes;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        resp_extra = 1'b0;
  logic        cmd_busy, cmd_done, timeout, spi_start;
  logic [7:0]  r1, spi_tx_data;
  logic [31:0] resp_data;
  logic        eng_busy = 1'b0;
  logic [7:0]  eng_rx = 8'h00;

  int n_chk = 0, n_pass = 0;
  int rise_lo = 0, rise_hi = 0, fall_lo = 2, fall_hi = 2;
  int eng_ph = 0, eng_cnt = 0, tot_bytes = 0, base = 0, rel = 0;
  int start_err = 0, stab_err = 0, ndone = 0;
  logic [7:0] eng_tx = 8'h00;
  logic [7:0] rsp_mem [0:63];
  logic [7:0] tx_log [0:255];
  vec_t vecs [6];

  always #5 clk = ~clk;

  sd_cmd_sequencer #(.RESP_POLL_MAX(8), .PRE_FF(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .resp_extra(resp_extra), .cmd_busy(cmd_busy),
    .cmd_done(cmd_done), .r1(r1), .resp_data(resp_data), .timeout(timeout),
    .spi_tx_data(spi_tx_data), .spi_start(spi_start), .spi_busy(eng_busy),
    .spi_rx_data(eng_rx)
  );

  // Byte engine: start -> rise delay -> busy for fall delay -> rx byte from script
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_ph <= 0; eng_busy <= 1'b0; eng_cnt <= 0;
    end else begin
      if (cmd_done) ndone <= ndone + 1;
      if (eng_ph != 0) begin
        if (spi_start) start_err <= start_err + 1;
        if (spi_tx_data !== eng_tx) stab_err <= stab_err + 1;
      end
      case (eng_ph)
        0: if (spi_start) begin
          eng_tx <= spi_tx_data;
          tx_log[tot_bytes % 256] <= spi_tx_data;
          tot_bytes <= tot_bytes + 1;
          eng_cnt <= int'($urandom_range(rise_hi, rise_lo));
          eng_ph <= 1;
        end
        1: if (eng_cnt == 0) begin
          eng_busy <= 1'b1;
          eng_cnt <= int'($urandom_range(fall_hi, fall_lo));
          eng_ph <= 2;
        end else eng_cnt <= eng_cnt - 1;
        default: if (eng_cnt == 0) begin
          rel = tot_bytes - 1 - base;
          eng_rx <= (rel >= 0 && rel < 64) ? rsp_mem[rel] : 8'hFF;
          eng_busy <= 1'b0;
          eng_ph <= 0;
        end else eng_cnt <= eng_cnt - 1;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic load_rsp(input vec_t v);
    for (int i = 0; i < 64; i++) rsp_mem[i] = 8'hFF;
    for (int i = 0; i < 8; i++) if (i < v.pos) rsp_mem[7+i] = v.noise;
    if (v.pos < 8) begin
      rsp_mem[7+v.pos] = v.r1b;
      for (int k = 0; k < 4; k++) rsp_mem[8+v.pos+k] = v.xw[31-8*k -: 8];
    end
    base = tot_bytes;
  endtask

  task automatic issue(input vec_t v, input string tag);
    @(negedge clk);
    cmd_index = v.idx; cmd_arg = v.arg; resp_extra = v.extra; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; resp_extra = 1'b0;
    chk({tag, "_busy_after_start"}, cmd_busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!cmd_done && n < 20000) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, cmd_done, 1);
  endtask

  task automatic chk_at_done(input vec_t v, input string tag);
    chk({tag, "_busy_at_done"}, cmd_busy, 0);
    chk({tag, "_r1"}, r1, v.e_r1);
    chk({tag, "_resp"}, resp_data, v.e_resp);
    chk({tag, "_timeout"}, timeout, v.e_tmo);
  endtask

  task automatic chk_after(input vec_t v, input string tag, input int d0);
    logic [55:0] got_f, exp_f;
    logic ok;
    repeat (3) @(negedge clk);
    exp_f = {8'hFF, 2'b01, v.idx, v.arg, v.crc_b};
    got_f = '0;
    for (int i = 0; i < 7; i++) got_f = {got_f[47:0], tx_log[(base+i) % 256]};
    ok = 1'b1;
    for (int i = 7; i < v.e_bytes; i++) if (tx_log[(base+i) % 256] !== 8'hFF) ok = 1'b0;
    chk({tag, "_frame"}, got_f, exp_f);
    chk({tag, "_poll_bytes_ff"}, ok, 1);
    chk({tag, "_byte_count"}, tot_bytes - base, v.e_bytes);
    chk({tag, "_done_pulses"}, ndone - d0, 1);
    chk({tag, "_start_per_byte"}, start_err, 0);
    chk({tag, "_tx_stable"}, stab_err, 0);
    chk({tag, "_idle_busy"}, cmd_busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int d0;
    load_rsp(v);
    d0 = ndone;
    issue(v, tag);
    wait_done(tag);
    chk_at_done(v, tag);
    chk_after(v, tag, d0);
  endtask

  initial begin
    int n, d0;
    //          idx    arg            ex   pos noise  r1b    xw            crc    e_r1   e_resp        tmo  bytes
    vecs[0] = '{6'd0,  32'h0000_0000, 1'b0, 1, 8'hFF, 8'h01, 32'h0,        8'h95, 8'h01, 32'h0,        1'b0, 9};
    vecs[1] = '{6'd8,  32'h0000_01AA, 1'b1, 0, 8'hFF, 8'h01, 32'h0000_01AA, 8'h87, 8'h01, 32'h0000_01AA, 1'b0, 12};
    vecs[2] = '{6'd58, 32'h0000_0000, 1'b1, 99, 8'hFF, 8'h00, 32'h0,       8'hFD, 8'hFF, 32'h0,        1'b1, 15};
    vecs[3] = '{6'd55, 32'h0000_0000, 1'b0, 0, 8'hFF, 8'h01, 32'h0,        8'h65, 8'h01, 32'h0,        1'b0, 8};
    vecs[4] = '{6'd41, 32'h4000_0000, 1'b0, 7, 8'h80, 8'h00, 32'h0,        8'h77, 8'h00, 32'h0,        1'b0, 15};
    vecs[5] = '{6'd58, 32'h0000_0000, 1'b1, 2, 8'hFE, 8'h00, 32'hC0FF_8000, 8'hFD, 8'h00, 32'hC0FF_8000, 1'b0, 14};

    #2 rst_n = 1'b0;
    #10;
    chk("rst_busy", cmd_busy, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_r1", r1, 0);
    chk("rst_resp", resp_data, 0);
    chk("rst_tx", spi_tx_data, 8'hFF);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Second start during SEND is ignored
    load_rsp(vecs[0]);
    d0 = ndone;
    issue(vecs[0], "midsend");
    n = 0;
    while ((tot_bytes - base) < 3 && n < 2000) begin @(negedge clk); n++; end
    cmd_index = 6'd55; cmd_arg = 32'hFFFF_FFFF; resp_extra = 1'b1; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; resp_extra = 1'b0;
    wait_done("midsend");
    chk_at_done(vecs[0], "midsend");
    chk_after(vecs[0], "midsend", d0);

    // Start coincident with cmd_done is dropped; results hold
    load_rsp(vecs[3]);
    d0 = ndone;
    issue(vecs[3], "donecyc");
    wait_done("donecyc");
    cmd_index = 6'd0; cmd_start = 1'b1;
    chk_at_done(vecs[3], "donecyc");
    @(negedge clk) cmd_start = 1'b0;
    chk_after(vecs[3], "donecyc", d0);
    chk("donecyc_r1_held", r1, 8'h01);
    run_vec(vecs[1], "after_donecyc");

    // Reset during the 3rd SEND byte, then a cold CMD0
    load_rsp(vecs[0]);
    issue(vecs[0], "rstmid");
    n = 0;
    while (!((tot_bytes - base) == 4 && eng_busy) && n < 2000) begin @(negedge clk); n++; end
    chk("rstmid_reached", (tot_bytes - base) == 4, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", cmd_busy, 0);
    chk("rstmid_spi_start", spi_start, 0);
    chk("rstmid_tx", spi_tx_data, 8'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], "cold_cmd0");

    // Variable engine timing
    rise_lo = 0; rise_hi = 5; fall_lo = 16; fall_hi = 64;
    run_vec(vecs[1], "var_cmd8");
    run_vec(vecs[2], "var_tmo");
    rise_lo = 0; rise_hi = 0; fall_lo = 2; fall_hi = 2;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
